// File: rtl/apb_master_bridge.sv
// APB initiator: turns single-beat commands into one SETUP+ACCESS transfer each,
// waits on PREADY (bounded by a timeout) and returns data/error on a response channel.
module apb_master_bridge #(
    parameter int unsigned data_size      = 8,
    parameter int unsigned addr_size      = 7,
    parameter int unsigned timeout_cycles = 15
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addr_size-1:0] cmd_addr,
    input  logic [data_size-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [data_size-1:0] rsp_rdata,
    output logic                 rsp_error,
    output logic                 PSELx,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [addr_size-1:0] PADDR,
    output logic [data_size-1:0] PWDATA,
    input  logic [data_size-1:0] PRDATA,
    input  logic                 PREADY
);

    localparam int unsigned CNT_W   = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam int unsigned TO_LAST = (timeout_cycles > 0) ? timeout_cycles - 1 : 0;
    localparam bit          TO_EN   = (timeout_cycles != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t               r_state,  w_state_nxt;
    logic                 r_pwrite, w_pwrite_nxt;
    logic [addr_size-1:0] r_paddr,  w_paddr_nxt;
    logic [data_size-1:0] r_pwdata, w_pwdata_nxt;
    logic [data_size-1:0] r_rdata,  w_rdata_nxt;
    logic                 r_error,  w_error_nxt;
    logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
    logic                 w_timeout;

    // Last permitted ACCESS cycle reached without PREADY
    assign w_timeout = TO_EN && (r_cnt == CNT_W'(TO_LAST));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state  <= IDLE;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_rdata  <= '0;
            r_error  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pwrite <= w_pwrite_nxt;
            r_paddr  <= w_paddr_nxt;
            r_pwdata <= w_pwdata_nxt;
            r_rdata  <= w_rdata_nxt;
            r_error  <= w_error_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pwrite_nxt = r_pwrite;
        w_paddr_nxt  = r_paddr;
        w_pwdata_nxt = r_pwdata;
        w_rdata_nxt  = r_rdata;
        w_error_nxt  = r_error;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_pwrite_nxt = cmd_write;
                    w_paddr_nxt  = cmd_addr;
                    w_pwdata_nxt = cmd_wdata;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = SETUP;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    w_rdata_nxt = r_pwrite ? '0 : PRDATA;
                    w_error_nxt = 1'b0;
                    w_state_nxt = RESP;
                end else if (w_timeout) begin
                    w_rdata_nxt = '0;
                    w_error_nxt = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Handshake and bus strobes decode straight from the state register
    assign cmd_ready = (r_state == IDLE);
    assign PSELx     = (r_state == SETUP) || (r_state == ACCESS);
    assign PENABLE   = (r_state == ACCESS);
    assign rsp_valid = (r_state == RESP);
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_rdata = r_rdata;
    assign rsp_error = r_error;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: latency, wait states, timeout,
// response backpressure and mid-transfer reset.
module tb_apb_master_bridge;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_error;
    logic       PSELx;
    logic       PENABLE;
    logic       PWRITE;
    logic [6:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;

    int n_chk  = 0;
    int n_pass = 0;

    apb_master_bridge #(
        .data_size      (8),
        .addr_size      (7),
        .timeout_cycles (15)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Present one command for the accept edge, then withdraw it
    task automatic send_cmd(input logic w, input logic [6:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // From SETUP: hold PREADY low for n_wait ACCESS cycles then raise it, until rsp_valid
    task automatic run_access(input int n_wait, input logic [7:0] rd,
                              output int acc, output bit stable);
        logic [6:0] a0;
        acc    = 0;
        stable = 1'b1;
        a0     = '0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (rsp_valid) break;
            if (PSELx && PENABLE) begin
                acc++;
                if (acc == 1) a0 = PADDR;
                else if (PADDR !== a0) stable = 1'b0;
                PREADY = (acc > n_wait);
                PRDATA = (acc > n_wait) ? rd : 8'hEE;
            end
        end
        chk("rsp_seen", 32'(rsp_valid), 32'd1);
    endtask

    int  acc;
    bit  stable;
    bit  ok;

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        PRDATA    = '0;
        PREADY    = 1'b0;
        repeat (2) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_psel",      32'(PSELx),     32'd0);
        chk("rst_penable",   32'(PENABLE),   32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_paddr",     32'(PADDR),     32'd0);
        PRESETn = 1'b1;
        tick();

        // Write, no wait: exact cycle-by-cycle latency
        PREADY = 1'b1;
        PRDATA = 8'hFF;
        chk("w_idle_ready", 32'(cmd_ready), 32'd1);
        send_cmd(1'b1, 7'h02, 8'hA5);
        chk("w_c1_psel",    32'(PSELx),     32'd1);
        chk("w_c1_penable", 32'(PENABLE),   32'd0);
        chk("w_c1_paddr",   32'(PADDR),     32'h02);
        chk("w_c1_pwrite",  32'(PWRITE),    32'd1);
        chk("w_c1_pwdata",  32'(PWDATA),    32'hA5);
        chk("w_c1_cmd_rdy", 32'(cmd_ready), 32'd0);
        tick();
        chk("w_c2_psel",    32'(PSELx),     32'd1);
        chk("w_c2_penable", 32'(PENABLE),   32'd1);
        tick();
        chk("w_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("w_c3_rsp_error", 32'(rsp_error), 32'd0);
        chk("w_c3_rsp_rdata", 32'(rsp_rdata), 32'h00);
        chk("w_c3_psel",      32'(PSELx),     32'd0);
        tick();
        chk("w_c4_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("w_c4_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("w_c4_pwdata",    32'(PWDATA),    32'hA5);

        // Read with 3 wait states
        send_cmd(1'b0, 7'h04, 8'h00);
        run_access(3, 8'h3C, acc, stable);
        chk("r3_acc_cycles", 32'(acc),       32'd4);
        chk("r3_paddr_stab", 32'(stable),    32'd1);
        chk("r3_rdata",      32'(rsp_rdata), 32'h3C);
        chk("r3_error",      32'(rsp_error), 32'd0);
        tick();

        // Timeout: PREADY never rises
        send_cmd(1'b0, 7'h06, 8'h00);
        run_access(100, 8'h55, acc, stable);
        chk("to_acc_cycles", 32'(acc),       32'd15);
        chk("to_error",      32'(rsp_error), 32'd1);
        chk("to_rdata",      32'(rsp_rdata), 32'h00);
        chk("to_psel",       32'(PSELx),     32'd0);
        chk("to_penable",    32'(PENABLE),   32'd0);
        tick();

        // PREADY on the final allowed ACCESS cycle completes normally
        send_cmd(1'b0, 7'h06, 8'h00);
        run_access(14, 8'h81, acc, stable);
        chk("to15_acc_cycles", 32'(acc),       32'd15);
        chk("to15_error",      32'(rsp_error), 32'd0);
        chk("to15_rdata",      32'(rsp_rdata), 32'h81);
        tick();

        // Response backpressure with a second command waiting
        rsp_ready = 1'b0;
        send_cmd(1'b0, 7'h0A, 8'h00);
        run_access(0, 8'h5A, acc, stable);
        chk("bp_rdata", 32'(rsp_rdata), 32'h5A);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 7'h10;
        cmd_wdata = 8'h77;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!rsp_valid || rsp_rdata !== 8'h5A || rsp_error !== 1'b0 ||
                cmd_ready !== 1'b0 || PSELx !== 1'b0) ok = 1'b0;
            tick();
        end
        chk("bp_stall_stable", 32'(ok), 32'd1);
        rsp_ready = 1'b1;
        tick();
        chk("bp_idle_ready", 32'(cmd_ready), 32'd1);
        chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("bp_acc2_psel",  32'(PSELx),  32'd1);
        chk("bp_acc2_paddr", 32'(PADDR),  32'h10);
        chk("bp_acc2_pwdat", 32'(PWDATA), 32'h77);
        run_access(0, 8'h99, acc, stable);
        chk("bp_w2_rdata", 32'(rsp_rdata), 32'h00);
        chk("bp_w2_error", 32'(rsp_error), 32'd0);
        tick();

        // Reset while a read is stalled in ACCESS
        PREADY = 1'b0;
        send_cmd(1'b0, 7'h08, 8'h33);
        tick();
        tick();
        chk("mr_in_access", 32'(PENABLE), 32'd1);
        PRESETn = 1'b0;
        #1;
        chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mr_psel",      32'(PSELx),     32'd0);
        chk("mr_penable",   32'(PENABLE),   32'd0);
        chk("mr_paddr",     32'(PADDR),     32'd0);
        chk("mr_pwdata",    32'(PWDATA),    32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || PSELx !== 1'b0) ok = 1'b0;
        end
        chk("mr_no_rsp", 32'(ok), 32'd1);
        send_cmd(1'b1, 7'h0C, 8'h42);
        run_access(0, 8'hAA, acc, stable);
        chk("mr_w_acc",   32'(acc),       32'd1);
        chk("mr_w_error", 32'(rsp_error), 32'd0);
        chk("mr_w_rdata", 32'(rsp_rdata), 32'h00);
        tick();
        chk("mr_w_idle", 32'(cmd_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
